// File: rtl/fir_filter_pkg.sv
// fir_filter_pkg: kernel description shared by the FIR datapath.
// Changing TAPS/SHIFT here reshapes the whole filter.
package fir_filter_pkg;

  localparam int TAPS       = 5;
  localparam int GAIN       = 10;
  localparam int GUARD_BITS = 4;

  // Tap 0 multiplies the newest sample.
  localparam logic [TAPS-1:0][1:0] SHIFT = {
    2'd0, 2'd1, 2'd2, 2'd1, 2'd0
  };

  function automatic int coef(input int k);
    return 1 << SHIFT[k];
  endfunction

endpackage

// File: rtl/fir_filter_if.sv
// fir_filter_if: sample stream bundle between a source and the filter.
// The source drives inData every cycle; the filter drives outData.
interface fir_filter_if #(
  parameter int signalSize = 32
);

  logic signed [signalSize-1:0] inData;
  logic signed [signalSize-1:0] outData;

  modport master (
    output inData,
    input  outData
  );

  modport slave (
    input  inData,
    output outData
  );

endinterface

// File: rtl/fir_delay_line.sv
// fir_delay_line: WIDTH x DEPTH shift register with synchronous clear.
// Tap 0 holds the most recently captured sample.
module fir_delay_line #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [WIDTH-1:0]            i_data,
  output logic [DEPTH-1:0][WIDTH-1:0] o_taps
);

  logic [DEPTH-1:0][WIDTH-1:0] r_taps;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_taps <= '0;
    end else begin
      r_taps[0] <= i_data;
      for (int k = 1; k < DEPTH; k++) begin
        r_taps[k] <= r_taps[k-1];
      end
    end
  end

  assign o_taps = r_taps;

endmodule

// File: rtl/fir_filter.sv
// fir_filter: 5-tap symmetric low-pass FIR (1,2,4,2,1), shift-add only.
// One sample per clock, registered output, wraps modulo 2^signalSize.
module fir_filter
  import fir_filter_pkg::*;
#(
  parameter int signalSize = 32
) (
  output logic signed [signalSize-1:0] outData,
  input  logic signed [signalSize-1:0] inData,
  input  logic                         clk,
  input  logic                         rst
);

  localparam int SW = signalSize + GUARD_BITS;

  logic [TAPS-2:0][signalSize-1:0] w_hist;
  logic [TAPS-1:0][signalSize-1:0] w_taps;
  logic [TAPS-1:0][SW-1:0]         w_term;
  logic [SW-1:0]                   w_sum;
  logic [signalSize-1:0]           r_out;

  fir_delay_line #(
    .WIDTH (signalSize),
    .DEPTH (TAPS-1)
  ) u_delay (
    .clk    (clk),
    .rst    (rst),
    .i_data (inData),
    .o_taps (w_hist)
  );

  assign w_taps[0] = inData;

  for (genvar k = 1; k < TAPS; k++) begin : g_tap
    assign w_taps[k] = w_hist[k-1];
  end

  // Sign-extend into guard bits before shifting so no term overflows.
  for (genvar k = 0; k < TAPS; k++) begin : g_term
    logic [SW-1:0] w_ext;
    assign w_ext = {{GUARD_BITS{w_taps[k][signalSize-1]}}, w_taps[k]};
    assign w_term[k] = w_ext << SHIFT[k];
  end

  always_comb begin
    w_sum = '0;
    for (int k = 0; k < TAPS; k++) begin
      w_sum = w_sum + w_term[k];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_out <= '0;
    end else begin
      r_out <= w_sum[signalSize-1:0];
    end
  end

  assign outData = r_out;

endmodule

// File: tb/tb_fir_filter.sv
// tb_fir_filter: directed and random checks of fir_filter at widths 32 and 8.
// Inputs change on the falling edge; outputs are sampled 1 time unit after the rising edge.
module tb_fir_filter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  fir_filter_if #(.signalSize(32)) bus32 ();
  fir_filter_if #(.signalSize(8))  bus8 ();

  fir_filter #(.signalSize(32)) u_dut32 (
    .outData (bus32.outData),
    .inData  (bus32.inData),
    .clk     (clk),
    .rst     (rst)
  );

  fir_filter #(.signalSize(8)) u_dut8 (
    .outData (bus8.outData),
    .inData  (bus8.inData),
    .clk     (clk),
    .rst     (rst)
  );

  always #5 clk = ~clk;

  task automatic step(input logic signed [31:0] a,
                      input logic signed [7:0] b,
                      input logic r);
    @(negedge clk);
    bus32.inData = a;
    bus8.inData  = b;
    rst          = r;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    bus32.inData = 32'sd77;
    bus8.inData  = 8'sd33;
    for (int i = 0; i < 3; i++) begin
      step(32'sd77, 8'sd33, 1'b1);
      checks++;
      if (bus32.outData !== 32'sd0) begin
        errors++;
        $display("FAIL reset32 cyc%0d got %0d want 0", i, bus32.outData);
      end
      checks++;
      if (bus8.outData !== 8'sd0) begin
        errors++;
        $display("FAIL reset8 cyc%0d got %0d want 0", i, bus8.outData);
      end
    end
  endtask

  task automatic test_impulse();
    int exp_v[7] = '{1, 2, 4, 2, 1, 0, 0};
    step(0, 0, 1'b1);
    for (int i = 0; i < 7; i++) begin
      step((i == 0) ? 32'sd1 : 32'sd0, 0, 1'b0);
      checks++;
      if (bus32.outData !== exp_v[i]) begin
        errors++;
        $display("FAIL impulse[%0d] got %0d want %0d", i, bus32.outData, exp_v[i]);
      end
    end
  endtask

  task automatic test_step();
    int exp_v[6] = '{100, 300, 700, 900, 1000, 1000};
    step(0, 0, 1'b1);
    for (int i = 0; i < 6; i++) begin
      step(32'sd100, 0, 1'b0);
      checks++;
      if (bus32.outData !== exp_v[i]) begin
        errors++;
        $display("FAIL step[%0d] got %0d want %0d", i, bus32.outData, exp_v[i]);
      end
    end
  endtask

  task automatic test_neg_step();
    int exp_v[6] = '{-5, -15, -35, -45, -50, -50};
    step(0, 0, 1'b1);
    for (int i = 0; i < 6; i++) begin
      step(-32'sd5, 0, 1'b0);
      checks++;
      if (bus32.outData !== exp_v[i]) begin
        errors++;
        $display("FAIL negstep[%0d] got %0d want %0d", i, bus32.outData, exp_v[i]);
      end
    end
    checks++;
    if (bus32.outData / 10 !== -5) begin
      errors++;
      $display("FAIL negstep_div got %0d want -5", bus32.outData / 10);
    end
  endtask

  task automatic test_mid_reset();
    int exp_v[7] = '{1, 2, 4, 2, 1, 0, 0};
    step(0, 0, 1'b1);
    for (int i = 0; i < 3; i++) step(32'sd100, 0, 1'b0);
    step(32'sd100, 0, 1'b1);
    checks++;
    if (bus32.outData !== 32'sd0) begin
      errors++;
      $display("FAIL midrst_hold got %0d want 0", bus32.outData);
    end
    for (int i = 0; i < 7; i++) begin
      step((i == 0) ? 32'sd1 : 32'sd0, 0, 1'b0);
      checks++;
      if (bus32.outData !== exp_v[i]) begin
        errors++;
        $display("FAIL midrst[%0d] got %0d want %0d", i, bus32.outData, exp_v[i]);
      end
    end
  endtask

  task automatic test_wrap();
    logic signed [7:0] e_pos[6] = '{127, 125, 121, 119, -10, -10};
    logic signed [7:0] e_neg[6] = '{-128, -128, -128, -128, 0, 0};
    step(0, 0, 1'b1);
    for (int i = 0; i < 6; i++) begin
      step(0, 8'sd127, 1'b0);
      checks++;
      if (bus8.outData !== e_pos[i]) begin
        errors++;
        $display("FAIL wrap_pos[%0d] got %0d want %0d", i, bus8.outData, e_pos[i]);
      end
    end
    step(0, 0, 1'b1);
    for (int i = 0; i < 6; i++) begin
      step(0, -8'sd128, 1'b0);
      checks++;
      if (bus8.outData !== e_neg[i]) begin
        errors++;
        $display("FAIL wrap_neg[%0d] got %0d want %0d", i, bus8.outData, e_neg[i]);
      end
    end
  endtask

  task automatic test_random();
    longint h1 = 0, h2 = 0, h3 = 0, h4 = 0;
    longint x, e;
    logic signed [31:0] e32;
    step(0, 0, 1'b1);
    for (int i = 0; i < 1005; i++) begin
      if (i < 1000)
        x = longint'($urandom_range(32'h1000_0000, 0)) - 64'sh0800_0000;
      else
        x = 0;
      e   = x + 2 * h1 + 4 * h2 + 2 * h3 + h4;
      e32 = e[31:0];
      step(x[31:0], 0, 1'b0);
      checks++;
      if (bus32.outData !== e32) begin
        errors++;
        $display("FAIL random[%0d] got %0d want %0d", i, bus32.outData, e32);
      end
      h4 = h3; h3 = h2; h2 = h1; h1 = x;
    end
    checks++;
    if (bus32.outData !== 32'sd0) begin
      errors++;
      $display("FAIL random_drain got %0d want 0", bus32.outData);
    end
  endtask

  initial begin
    bus32.inData = '0;
    bus8.inData  = '0;
    test_reset();
    test_impulse();
    test_step();
    test_neg_step();
    test_mid_reset();
    test_wrap();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
